// File: rtl/int_arith_pkg.sv
// Shared integer-arithmetic definitions for the sequential multiplier and divider:
// default width, control-state encoding and sign-magnitude helpers.
package int_arith_pkg;

  localparam int DEFAULT_W = 8;
  // Widest operand the helper functions handle; callers extend into and truncate out of this.
  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Magnitude of a sign-extended operand. Truncated back to W bits, |-2^(W-1)| is exact.
  function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] x);
    return x[MAX_W-1] ? (~x + MAX_W'(1)) : x;
  endfunction

  // Two's-complement negation of a double-width value.
  function automatic logic [2*MAX_W-1:0] neg2(input logic [2*MAX_W-1:0] x);
    return ~x + (2*MAX_W)'(1);
  endfunction

endpackage

// File: rtl/mul_datapath.sv
// Unsigned shift-add core: multiplies two W-bit magnitudes, one multiplier bit per step,
// LSB first, leaving the 2W-bit product in the accumulator after W steps.
module mul_datapath
  import int_arith_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   a_mag,
  input  logic [W-1:0]   b_mag,
  output logic [2*W-1:0] acc,
  output logic           last
);

  localparam int CNT_W = $clog2(W) + 1;

  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W:0]       upper_sum;

  always_comb begin
    // The extra top bit keeps the carry of the partial-product add for the right shift.
    upper_sum = {1'b0, acc_q[2*W-1:W]};
    if (b_q[0]) begin
      upper_sum = upper_sum + {1'b0, a_q};
    end
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (load) begin
      a_d   = a_mag;
      b_d   = b_mag;
      acc_d = '0;
      cnt_d = '0;
    end else if (step) begin
      acc_d = {upper_sum, acc_q[W-1:1]};
      b_d   = b_q >> 1;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc  = acc_q;
  assign last = (cnt_q == CNT_W'(W - 1));

endmodule

// File: rtl/int_mul_seq.sv
// Iterative signed multiply-accumulate p = a*b + c with valid/ready handshakes;
// sign-magnitude core, sign and addend applied in a single FIX cycle.
module int_mul_seq
  import int_arith_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [W-1:0]   c,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);

  state_e state_q, state_d;

  logic           sign_q, sign_d;
  logic [2*W-1:0] c_ext_q, c_ext_d;
  logic [2*W-1:0] p_q, p_d;
  logic           out_valid_q, out_valid_d;

  logic           accept;
  logic           step;
  logic           last;
  logic [W-1:0]   a_abs;
  logic [W-1:0]   b_abs;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_s;

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == RUN) || (state_q == FIX);
  assign accept   = in_valid && in_ready;
  assign step     = (state_q == RUN);

  assign a_abs = W'(abs_mag(MAX_W'($signed(a))));
  assign b_abs = W'(abs_mag(MAX_W'($signed(b))));
  assign acc_s = sign_q ? (2*W)'(neg2((2*MAX_W)'(acc))) : acc;

  mul_datapath #(
    .W(W)
  ) u_datapath (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .step  (step),
    .a_mag (a_abs),
    .b_mag (b_abs),
    .acc   (acc),
    .last  (last)
  );

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    c_ext_d     = c_ext_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = a[W-1] ^ b[W-1];
          c_ext_d = (2*W)'($signed(c));
          state_d = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_d = FIX;
        end
      end
      FIX: begin
        p_d         = acc_s + c_ext_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        // p stays untouched on drain; it only changes at the next FIX.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      c_ext_q     <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      c_ext_q     <= c_ext_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign p         = p_q;

endmodule

// File: tb/tb_int_mul_seq.sv
// Scoreboard bench for int_mul_seq (W=8): the driver queues expected results at accept,
// a negedge monitor checks latency and p on every output handshake.
module tb_int_mul_seq;

  localparam int W = 8;

  typedef struct {
    logic [2*W-1:0] p;
    int             cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [W-1:0]   c = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] p;
  logic           busy;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_txn = 0;
  int   cyc = 0;
  logic ov_prev = 1'b0;
  exp_t sb_q[$];

  int_mul_seq #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: latency on the rising edge of out_valid, value on each handshake.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      ov_prev <= 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got p=0x%0h with nothing issued, required no result", p);
        end else begin
          check("latency", cyc - sb_q[0].cyc, W + 1);
        end
      end
      if (out_valid && out_ready && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_txn++;
        $display("txn %0d: p=%0d expected=%0d", n_txn, $signed(p), $signed(e.p));
        check("p", p, e.p);
      end
      ov_prev <= out_valid;
    end
  end

  // Called at posedge+1; leaves in_valid high so back-to-back issue keeps it asserted.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] ic,
                       input logic [2*W-1:0] exp_p, output int acc_cyc);
    int guard;
    exp_t e;
    guard = 0;
    a = ia;
    b = ib;
    c = ic;
    in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, required 1");
      acc_cyc = -1;
    end else begin
      @(posedge clk);
      #1;
      e.p   = exp_p;
      e.cyc = cyc;
      sb_q.push_back(e);
      acc_cyc = cyc;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb_q.size() != 0 || !in_ready) && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d results pending, required 0", sb_q.size());
    end
  endtask

  logic [W-1:0]   va[8];
  logic [W-1:0]   vb[8];
  logic [W-1:0]   vc[8];
  logic [2*W-1:0] vp[8];

  initial begin : stim
    int t;
    int last_t;
    logic signed [W-1:0] ra, rb, rc;
    int ref_p;

    // Round-trip vectors then corners, expected values worked out by hand.
    va[0] = 8'd0;    vb[0] = 8'd80;   vc[0] = 8'd10;   vp[0] = 16'd10;
    va[1] = 8'd3;    vb[1] = 8'd34;   vc[1] = 8'd18;   vp[1] = 16'd120;
    va[2] = 8'd6;    vb[2] = 8'hF8;   vc[2] = 8'hFF;   vp[2] = 16'hFFCF;
    va[3] = 8'hFE;   vb[3] = 8'd16;   vc[3] = 8'd0;    vp[3] = 16'hFFE0;
    va[4] = 8'hFD;   vb[4] = 8'hF0;   vc[4] = 8'd0;    vp[4] = 16'd48;
    va[5] = 8'h80;   vb[5] = 8'h80;   vc[5] = 8'd0;    vp[5] = 16'h4000;
    va[6] = 8'h80;   vb[6] = 8'd127;  vc[6] = 8'h80;   vp[6] = 16'hC000;
    va[7] = 8'd127;  vb[7] = 8'd0;    vc[7] = 8'hFF;   vp[7] = 16'hFFFF;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_p", p, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      issue(va[i], vb[i], vc[i], vp[i], t);
      in_valid = 1'b0;
      check("busy_in_run", busy, 1);
      drain();
    end

    // Backpressure
    out_ready = 1'b0;
    issue(8'd5, 8'd7, 8'd0, 16'd35, t);
    in_valid = 1'b0;
    repeat (W + 1) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_p", p, 35);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);

    // Reset in the middle of RUN
    issue(8'd9, 8'd9, 8'd0, 16'd81, t);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_p", p, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(8'd2, 8'd3, 8'd1, 16'd7, t);
    in_valid = 1'b0;
    drain();

    // Inputs wiggled during RUN must be ignored
    issue(8'hF9, 8'd11, 8'd4, 16'hFFB7, t);
    for (int i = 0; i < 5; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      c = 8'($urandom);
      in_valid = i[0];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();
    repeat (15) @(posedge clk);
    #1;
    check("no_extra_txn_busy", busy, 0);
    check("no_extra_txn_out_valid", out_valid, 0);

    // Back-to-back random vectors against a reference product
    last_t = -1;
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = W'($urandom);
      ref_p = int'(ra) * int'(rb) + int'(rc);
      issue(ra, rb, rc, 16'(ref_p), t);
      if (last_t >= 0 && t >= 0) begin
        check("issue_interval", t - last_t, W + 3);
      end
      last_t = t;
    end
    in_valid = 1'b0;
    drain();

    check("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/int_mul_seq.md
# int_mul_seq

Iterative signed shift-add multiply-accumulate unit computing p = a·b + c over W-bit two's-complement operands. It is the inverse companion of the integer divider: given (quotient, divisor, remainder) it reconstructs the dividend, and it also serves as the scaling multiplier in the moving-average datapath. It uses the same sign-magnitude internal scheme as the divider, with valid/ready handshakes on both sides.

## Interface
- W, 8, operand width in bits (two's complement); must be ≥ 2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand set a/b/c is valid
- in_ready  out  1  block can accept operands; high only in IDLE
- a  in  W  signed multiplicand (e.g. quotient)
- b  in  W  signed multiplier (e.g. divisor)
- c  in  W  signed addend (e.g. remainder), sign-extended to 2W
- out_valid  out  1  p holds a completed result
- out_ready  in  1  consumer accepts p
- p  out  2W  signed result a·b + c
- busy  out  1  high in RUN and FIX

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE: in_ready=1. On in_valid && in_ready, capture |a| and |b| as W-bit magnitudes (|−2^(W−1)| = 2^(W−1) fits unsigned), sign = a[W−1]^b[W−1], c sign-extended to 2W, clear the accumulator and counter, and go to RUN.
- RUN: one multiplier bit per cycle, LSB first. If the current bit of |b| is 1, add |a| to the upper half of the accumulator; then shift the accumulator right by one and increment the counter. After W iterations, go to FIX.
- FIX: acc_s = sign ? −acc : acc; p ← acc_s + c_ext. Go to DONE.
- DONE: out_valid=1, p held stable. On out_ready, go to IDLE. in_ready stays 0 in DONE, so there is no overlap of accept and drain.
- Width rules: the result is exact, and overflow is impossible for any W. The extremes for W=8 are (−128)(−128)+127 = 16511 and (−128)(127)−128 = −16384, both within 16-bit signed range.
- Inputs a, b and c are ignored outside the accepting edge, and may change freely while busy.
- Zero operand: still W RUN cycles. Latency is data-independent.
- Reset: async assertion from any state forces IDLE. out_valid=0, busy=0, p=0, accumulator=0, counter=0. in_ready is decoded from IDLE, so it reads 1 during and after reset. No handshake completes while rst_n=0.

## Timing
- Accept at edge k. RUN occupies edges k+1..k+W. The FIX→DONE transition is at edge k+W+1, where out_valid rises and p is valid.
- Accept-to-result latency is W+1 cycles (9 for W=8).
- Minimum issue interval is W+3 cycles: accept, W RUN cycles, FIX, one DONE cycle with out_ready=1, then back in IDLE.
- out_valid and p are registered. in_ready and busy decode from the state register.
- out_ready held low: stay in DONE indefinitely with p and out_valid unchanged.
- in_valid asserted in a non-IDLE state: ignored, with no queuing.

## Structure
- Shared package int_arith_pkg holds:
  - the default width constant (8), shared with int_div;
  - the state enum {IDLE, RUN, FIX, DONE};
  - a function for W-bit absolute value and for 2W negation.
- One sub-module is natural: mul_datapath, holding the accumulator, counter and shift-add logic. The FSM and handshake stay in int_mul_seq.
- Counter width is $clog2(W)+1.

## Test plan
- Divider round-trip vectors (W=8, out_ready=1), each with p after exactly 9 cycles:
  - a=0, b=80, c=10 → p=10
  - a=3, b=34, c=18 → p=120
  - a=6, b=−8, c=−1 → p=−49
  - a=−2, b=16, c=0 → p=−32
  - a=−3, b=−16, c=0 → p=48
- Corners:
  - a=−128, b=−128, c=0 → p=16384 (0x4000)
  - a=−128, b=127, c=−128 → p=−16384 (0xC000)
  - a=127, b=0, c=−1 → p=−1 (0xFFFF)
- Backpressure: a=5, b=7, c=0 with out_ready low for 6 cycles → out_valid held, p=35 stable, in_ready=0; raise out_ready → IDLE next cycle.
- Ignored input: toggle a, b, c and in_valid during RUN → result unaffected, no second transaction started.
- Reset mid-RUN: assert rst_n low at RUN iteration 4 → out_valid=0, p=0, busy=0 immediately; after release, a=2, b=3, c=1 → p=7 with normal latency.
- Back-to-back: continuous in_valid with out_ready=1 → new accept every 11 cycles, and every result matches a·b+c over 1000 random vectors checked against a reference model.
